// File: rtl/arriskv_lsu_if.sv
// arriskv LSU shared types and the issue/memory bundle.
// The LSU uses the slave view; the issue stage and memory side use master.
package arriskv_pkg;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ALU,
        OP_LB,
        OP_LH,
        OP_LW,
        OP_LBU,
        OP_LHU,
        OP_SB,
        OP_SH,
        OP_SW
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [31:0] arg1;
        logic [31:0] arg2;
        logic [31:0] imm_se;
        logic [4:0]  rdest;
    } decoded_op_t;

endpackage

interface arriskv_lsu_if;

    logic                     op_valid_i;
    logic                     op_ready_o;
    arriskv_pkg::decoded_op_t op_i;
    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [31:0]              mem_addr_o;
    logic [3:0]               mem_be_o;
    logic [31:0]              mem_wdata_o;
    logic                     mem_gnt_i;
    logic                     mem_rvalid_i;
    logic [31:0]              mem_rdata_i;
    logic                     wb_valid_o;
    logic [4:0]               wb_rdest_o;
    logic [31:0]              wb_data_o;
    logic                     err_o;
    logic [1:0]               err_cause_o;
    logic                     busy_o;

    modport slave (
        input  op_valid_i, op_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output op_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
        output mem_wdata_o, wb_valid_o, wb_rdest_o, wb_data_o,
        output err_o, err_cause_o, busy_o
    );

    modport master (
        output op_valid_i, op_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  op_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
        input  mem_wdata_o, wb_valid_o, wb_rdest_o, wb_data_o,
        input  err_o, err_cause_o, busy_o
    );

endinterface

// File: rtl/arriskv_lsu.sv
// arriskv load/store unit: address generation, req/gnt/rvalid
// memory handshake, store lane steering and load extension.
module arriskv_lsu
    import arriskv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    arriskv_lsu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e      state;
    op_e         op_q;
    logic [31:0] ea_q;
    logic [4:0]  rdest_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] cnt;
    logic        wb_valid_q;
    logic [4:0]  wb_rdest_q;
    logic [31:0] wb_data_q;
    logic        err_q;
    logic [1:0]  cause_q;

    logic [31:0] ea;
    logic [1:0]  off;
    logic        is_load;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        misal;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] cnt_n;
    logic        expire;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;

    always_comb begin
        ea       = bus.op_i.arg1 + bus.op_i.imm_se;
        off      = ea[1:0];
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        be_n     = 4'b1111;
        wdata_n  = bus.op_i.arg2;
        unique case (bus.op_i.op)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load = 1'b1;
                is_half = 1'b1;
            end
            OP_LW: begin
                is_load = 1'b1;
                is_word = 1'b1;
            end
            OP_SB: begin
                is_store = 1'b1;
                be_n     = 4'b0001 << off;
                wdata_n  = {4{bus.op_i.arg2[7:0]}};
            end
            OP_SH: begin
                is_store = 1'b1;
                is_half  = 1'b1;
                be_n     = 4'b0011 << off;
                wdata_n  = {2{bus.op_i.arg2[15:0]}};
            end
            OP_SW: begin
                is_store = 1'b1;
                is_word  = 1'b1;
            end
            default: ;
        endcase
        misal = (is_half & off[0]) | (is_word & (off != 2'b00));
    end

    // Timeout fires on the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT.
    assign cnt_n  = cnt + 32'd1;
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_n == TIMEOUT_CYCLES);

    always_comb begin
        byte_v = bus.mem_rdata_i[{ea_q[1:0], 3'b000} +: 8];
        half_v = ea_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        unique case (op_q)
            OP_LB:   load_v = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_v = {24'b0, byte_v};
            OP_LH:   load_v = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_v = {16'b0, half_v};
            default: load_v = bus.mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= OP_NOP;
            ea_q       <= '0;
            rdest_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            wb_valid_q <= 1'b0;
            wb_rdest_q <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
            cause_q    <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            cause_q    <= 2'd0;
            unique case (state)
                IDLE: begin
                    if (bus.op_valid_i) begin
                        if (misal) begin
                            err_q   <= 1'b1;
                            cause_q <= 2'd1;
                        end else if (is_load | is_store) begin
                            op_q    <= bus.op_i.op;
                            ea_q    <= ea;
                            rdest_q <= bus.op_i.rdest;
                            we_q    <= is_store;
                            be_q    <= be_n;
                            wdata_q <= wdata_n;
                            cnt     <= '0;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt_n;
                    if (expire) begin
                        err_q   <= 1'b1;
                        cause_q <= 2'd2;
                        state   <= IDLE;
                    end else if (bus.mem_gnt_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt_n;
                    if (bus.mem_rvalid_i) begin
                        state <= IDLE;
                        if (!we_q && rdest_q != 5'd0) begin
                            wb_valid_q <= 1'b1;
                            wb_rdest_q <= rdest_q;
                            wb_data_q  <= load_v;
                        end
                    end else if (expire) begin
                        err_q   <= 1'b1;
                        cause_q <= 2'd2;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.op_ready_o  = (state == IDLE) && !rst;
    assign bus.mem_req_o   = (state == REQ) && !rst;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = {ea_q[31:2], 2'b00};
    assign bus.mem_be_o    = be_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.wb_valid_o  = wb_valid_q;
    assign bus.wb_rdest_o  = wb_rdest_q;
    assign bus.wb_data_o   = wb_data_q;
    assign bus.err_o       = err_q;
    assign bus.err_cause_o = cause_q;
    assign bus.busy_o      = (state != IDLE);

endmodule

// File: tb/tb_arriskv_lsu.sv
// Scoreboard bench for arriskv_lsu: random and directed ops, a
// scripted memory responder and a negedge monitor.
module tb_arriskv_lsu;
    import arriskv_pkg::*;

    localparam int T = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    arriskv_lsu_if bus();

    arriskv_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int gdly; int rdly; logic [31:0] rdata; bit nogrant; bit glitch;
    } plan_t;
    typedef struct {
        int cyc; logic [31:0] addr; logic [3:0] be; logic we;
        logic [31:0] wdata;
    } req_t;
    typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wb_t;
    typedef struct { int cyc; logic [1:0] cause; } err_t;

    plan_t plan_q[$];
    req_t  req_q[$];
    wb_t   wb_q[$];
    err_t  eq_err[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic plan_t mkplan(int g, int r, logic [31:0] d,
                                     bit ng, bit gl);
        plan_t p;
        p.gdly = g; p.rdly = r; p.rdata = d; p.nogrant = ng; p.glitch = gl;
        return p;
    endfunction

    function automatic int size_of(op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit is_st(op_e op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [31:0] ld_result(op_e op, logic [31:0] rd,
                                              int off);
        int sz = size_of(op);
        logic [63:0] w;
        w = {32'b0, rd} >> (8 * off);
        w = w & ((64'd1 << (8 * sz)) - 64'd1);
        if ((op == OP_LB || op == OP_LH) && w[8*sz-1])
            w = w - (64'd1 << (8 * sz));
        return w[31:0];
    endfunction

    task automatic issue(op_e op, logic [31:0] a1, logic [31:0] a2,
                         logic [31:0] imm, logic [4:0] rd, plan_t p,
                         bit completes);
        int w = 0;
        int sz, off;
        logic [31:0] ea, wd;
        logic [3:0] be;
        req_t r;
        while (!bus.op_ready_o && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", {31'b0, bus.op_ready_o}, 32'd1);
        bus.op_valid_i = 1'b1;
        bus.op_i = '{op: op, arg1: a1, arg2: a2, imm_se: imm, rdest: rd};
        ea = a1 + imm;
        off = int'(ea[1:0]);
        sz = size_of(op);
        if (sz != 0) begin
            if (off % sz != 0) begin
                eq_err.push_back('{cyc: cyc + 1, cause: 2'd1});
            end else begin
                be = 4'b1111;
                wd = a2;
                if (is_st(op)) begin
                    be = 4'(((1 << sz) - 1) << off);
                    for (int i = 0; i < 4; i++)
                        wd[8*i +: 8] = a2[8*(i % sz) +: 8];
                end
                r.cyc = cyc + 1;
                r.addr = {ea[31:2], 2'b00};
                r.be = be;
                r.we = is_st(op);
                r.wdata = wd;
                req_q.push_back(r);
                plan_q.push_back(p);
                if (completes) begin
                    if (p.nogrant)
                        eq_err.push_back('{cyc: cyc + 1 + T, cause: 2'd2});
                    else if (!is_st(op) && rd != 5'd0)
                        wb_q.push_back('{cyc: cyc + 3 + p.gdly + p.rdly,
                                         rd: rd,
                                         data: ld_result(op, p.rdata, off)});
                end
            end
        end
        @(negedge clk);
        bus.op_valid_i = 1'b0;
        bus.op_i = '{op: OP_NOP, arg1: $urandom, arg2: $urandom,
                     imm_se: $urandom, rdest: 5'($urandom)};
    endtask

    // Memory responder follows the plan pushed for each request.
    initial begin
        plan_t p;
        int w;
        bus.mem_gnt_i = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req_o && plan_q.size() > 0) begin
                p = plan_q.pop_front();
                if (p.nogrant) begin
                    w = 0;
                    while (bus.mem_req_o && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    repeat (3) @(negedge clk);
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i = $urandom;
                    @(negedge clk);
                    bus.mem_rvalid_i = 1'b0;
                end else begin
                    repeat (p.gdly) @(negedge clk);
                    bus.mem_gnt_i = 1'b1;
                    if (p.glitch) begin
                        bus.mem_rvalid_i = 1'b1;
                        bus.mem_rdata_i = ~p.rdata;
                    end
                    @(negedge clk);
                    bus.mem_gnt_i = 1'b0;
                    bus.mem_rvalid_i = 1'b0;
                    repeat (p.rdly) @(negedge clk);
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i = p.rdata;
                    @(negedge clk);
                    bus.mem_rvalid_i = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        bit prev_req = 1'b0;
        bit have = 1'b0;
        req_t cur;
        wb_t wx;
        err_t ex;
        forever begin
            @(negedge clk);
            if (bus.mem_req_o) begin
                if (!prev_req) begin
                    if (req_q.size() == 0) begin
                        checks++; errors++; have = 1'b0;
                        $display("FAIL unexpected_req: addr %h, none expected",
                                 bus.mem_addr_o);
                    end else begin
                        cur = req_q.pop_front();
                        have = 1'b1;
                        chk("req_cycle", cyc, cur.cyc);
                    end
                end
                if (have) begin
                    chk("req_addr", bus.mem_addr_o, cur.addr);
                    chk("req_be", {28'b0, bus.mem_be_o}, {28'b0, cur.be});
                    chk("req_we", {31'b0, bus.mem_we_o}, {31'b0, cur.we});
                    if (cur.we) chk("req_wdata", bus.mem_wdata_o, cur.wdata);
                end
            end
            prev_req = bus.mem_req_o;
            if (bus.wb_valid_o) begin
                if (wb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wb: rd %0d data %h, none expected",
                             bus.wb_rdest_o, bus.wb_data_o);
                end else begin
                    wx = wb_q.pop_front();
                    chk("wb_cycle", cyc, wx.cyc);
                    chk("wb_rdest", {27'b0, bus.wb_rdest_o}, {27'b0, wx.rd});
                    chk("wb_data", bus.wb_data_o, wx.data);
                end
            end
            if (bus.err_o) begin
                if (eq_err.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: cause %0d, none expected",
                             bus.err_cause_o);
                end else begin
                    ex = eq_err.pop_front();
                    chk("err_cycle", cyc, ex.cyc);
                    chk("err_cause", {30'b0, bus.err_cause_o}, {30'b0, ex.cause});
                end
            end
            if (bus.err_o && bus.wb_valid_o) begin
                checks++; errors++;
                $display("FAIL err_and_wb: both high, required exclusive");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        op_e ops[10] = '{OP_NOP, OP_ALU, OP_LB, OP_LH, OP_LW,
                         OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        plan_t p0;
        p0 = mkplan(0, 0, 32'h80FF7F01, 1'b0, 1'b0);
        bus.op_valid_i = 1'b0;
        bus.op_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.op_ready_o}, 32'd0);
        chk("rst_req", {31'b0, bus.mem_req_o}, 32'd0);
        chk("rst_wb", {31'b0, bus.wb_valid_o}, 32'd0);
        chk("rst_err", {31'b0, bus.err_o}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy_o}, 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'd0);
        chk("rst_be", {28'b0, bus.mem_be_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, bus.op_ready_o}, 32'd1);

        issue(OP_LW, 32'h1000, 32'h0, 32'd4, 5'd5,
              mkplan(0, 0, 32'hDEADBEEF, 1'b0, 1'b0), 1'b1);
        issue(OP_LB, 32'h2000, 32'h0, 32'd3, 5'd7, p0, 1'b1);
        issue(OP_LBU, 32'h2000, 32'h0, 32'd3, 5'd8, p0, 1'b1);
        issue(OP_LH, 32'h2000, 32'h0, 32'd2, 5'd9, p0, 1'b1);
        issue(OP_LHU, 32'h2000, 32'h0, 32'd2, 5'd10, p0, 1'b1);

        issue(OP_SB, 32'h3000, 32'h12345678, 32'd2, 5'd11, p0, 1'b1);
        repeat (2) @(negedge clk);
        chk("store_ready_after", {31'b0, bus.op_ready_o}, 32'd1);
        issue(OP_SH, 32'h3000, 32'h12345678, 32'd2, 5'd12, p0, 1'b1);
        repeat (2) @(negedge clk);
        chk("store_ready_after2", {31'b0, bus.op_ready_o}, 32'd1);

        issue(OP_LW, 32'h1000, 32'h0, 32'd2, 5'd3, p0, 1'b1);
        issue(OP_LW, 32'h1000, 32'h0, 32'd8, 5'd4,
              mkplan(1, 1, 32'hCAFEF00D, 1'b0, 1'b0), 1'b1);
        issue(OP_ALU, 32'h1000, 32'h0, 32'd0, 5'd6, p0, 1'b1);
        issue(OP_LB, 32'h2000, 32'h0, 32'd3, 5'd0, p0, 1'b1);

        issue(OP_LW, 32'h4000, 32'h0, 32'd0, 5'd6,
              mkplan(0, 0, 32'h0, 1'b1, 1'b0), 1'b1);
        repeat (T - 1) @(negedge clk);
        chk("to_req_last", {31'b0, bus.mem_req_o}, 32'd1);
        @(negedge clk);
        chk("to_req_drop", {31'b0, bus.mem_req_o}, 32'd0);
        chk("to_busy", {31'b0, bus.busy_o}, 32'd0);
        repeat (8) @(negedge clk);

        issue(OP_LW, 32'h5000, 32'h0, 32'd0, 5'd10,
              mkplan(0, 6, 32'h11111111, 1'b0, 1'b0), 1'b0);
        @(negedge clk);
        chk("rstw_busy", {31'b0, bus.busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_ready", {31'b0, bus.op_ready_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstw_ready_after", {31'b0, bus.op_ready_o}, 32'd1);
        repeat (12) @(negedge clk);

        issue(OP_LW, 32'h6000, 32'h0, 32'd0, 5'd10,
              mkplan(0, 0, 32'h0, 1'b1, 1'b0), 1'b0);
        chk("rstr_req", {31'b0, bus.mem_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstr_req_drop", {31'b0, bus.mem_req_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstr_ready_after", {31'b0, bus.op_ready_o}, 32'd1);
        repeat (10) @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] imm;
            imm = 32'($urandom_range(0, 31)) - 32'd16;
            issue(ops[$urandom_range(0, 9)], $urandom, $urandom, imm,
                  5'($urandom),
                  mkplan($urandom_range(0, 2), $urandom_range(0, 3),
                         $urandom, 1'b0, $urandom_range(0, 3) == 0),
                  1'b1);
        end

        repeat (20) @(negedge clk);
        chk("req_q_empty", req_q.size(), 32'd0);
        chk("wb_q_empty", wb_q.size(), 32'd0);
        chk("err_q_empty", eq_err.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arriskv_lsu.md
# arriskv_lsu

Load/store unit for the arriskv core: the execute-side consumer of `decoded_op_t` for LB/LH/LW/LBU/LHU/SB/SH/SW. It sits between the decode/issue stage and the data-memory port. It forms the effective address, drives a req/gnt/rvalid memory handshake with byte enables, and aligns and extends load data. Results go to the register-file writeback port; misaligned accesses and memory timeouts are reported as error pulses.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in REQ+WAIT before the access is abandoned. 0 disables the timeout.
- `clk`  in  1  core clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid_i`  in  1  decoded op offered.
- `op_ready_o`  out  1  LSU can accept an op. High only in IDLE with `rst` low.
- `op_i`  in  `decoded_op_t`  uses fields `op`, `arg1` (rs1 value), `arg2` (rs2 value), `imm_se`, `rdest`.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = store.
- `mem_addr_o`  out  32  word address; bits [1:0] are always 0.
- `mem_be_o`  out  4  byte enables.
- `mem_wdata_o`  out  32  store data, replicated into lanes.
- `mem_gnt_i`  in  1  request accepted.
- `mem_rvalid_i`  in  1  response valid; returned for both loads and stores.
- `mem_rdata_i`  in  32  load data.
- `wb_valid_o`  out  1  one-cycle writeback pulse.
- `wb_rdest_o`  out  5  destination register.
- `wb_data_o`  out  32  extended load result.
- `err_o`  out  1  one-cycle error pulse.
- `err_cause_o`  out  2  1 = misaligned, 2 = timeout, 0 otherwise. Valid with `err_o`.
- `busy_o`  out  1  state is not IDLE.

## Operation
**Address and alignment**
- Effective address `ea = arg1 + imm_se`, 32-bit wrap-around. `off = ea[1:0]`.
- Misaligned: LH/LHU/SH with `off[0]=1`; LW/SW with `off != 0`. Byte accesses are never misaligned.

**States: IDLE, REQ, WAIT**
- IDLE, on accept (`op_valid_i & op_ready_o`):
  - Op not a load/store: consumed and dropped. No memory access, no writeback, no error.
  - Misaligned: no memory access. `err_o=1`, `err_cause_o=1` on the next cycle. Stay in IDLE.
  - Otherwise: latch `ea`, `op`, `rdest`, and the store lanes, then go to REQ.
- REQ:
  - `mem_req_o=1`. `mem_addr_o = {ea[31:2],2'b00}`, and `we`/`be`/`wdata` are held stable until `mem_gnt_i`.
  - On gnt: go to WAIT.
- WAIT:
  - On `mem_rvalid_i`, load: register the writeback and go to IDLE.
  - On `mem_rvalid_i`, store: go to IDLE with no writeback.
- Timeout:
  - A counter clears on accept and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES` (nonzero) it abandons the access: `mem_req_o` drops, `err_o=1` with cause 2 the next cycle, state returns to IDLE.

**Store lanes**
- SB: `be = 4'b0001 << off`, `wdata = {4{arg2[7:0]}}`.
- SH: `be = 4'b0011 << off`, `wdata = {2{arg2[15:0]}}`.
- SW: `be = 4'b1111`, `wdata = arg2`.
- Loads: `be = 4'b1111`, `we = 0`.

**Load extraction**
- LB/LBU: byte `rdata[8*off +: 8]`, sign- or zero-extended.
- LH/LHU: half `rdata[16*off[1] +: 16]`, sign- or zero-extended.
- LW: full word.

**Writeback**
- Writeback is suppressed when `rdest == 0`. The access still completes.

## Timing
- Reset values:
  - All outputs 0; state IDLE; counter 0.
  - `op_ready_o = 0` while `rst` is high, 1 from the first cycle after.
- Accept in cycle N → `mem_req_o` high from N+1. Earliest gnt is N+1, earliest rvalid N+2.
- `wb_valid_o`, `wb_data_o` and `wb_rdest_o` are registered: they appear for one cycle, in the cycle after rvalid, which is also the first IDLE cycle.
- Minimum load-to-load issue interval is 3 cycles. A misaligned accept keeps `op_ready_o` high, so the next op can be accepted at N+1.
- `mem_rvalid_i` is ignored in IDLE and REQ. rvalid in the gnt cycle is a protocol violation and is ignored. A late rvalid after a timeout or reset is ignored.
- `rst` mid-access: abandon immediately; `mem_req_o` is 0 in the reset cycle; no writeback; no error.
- `err_o` and `wb_valid_o` are never high in the same cycle.

## Test plan
- LW, `arg1=0x1000`, `imm_se=4`, `rdest=5`, gnt at N+1, rvalid at N+2 with `0xDEADBEEF` → `mem_addr_o=0x1004`, `be=1111`, `wb_valid_o` at N+3 with `rdest=5`, `data=0xDEADBEEF`.
- Loads at `ea=0x2003` with `rdata=0x80FF7F01`:
  - LB → `0xFFFFFF80`.
  - LBU → `0x00000080`.
  - LH at `0x2002` → `0xFFFF80FF`.
  - LHU → `0x000080FF`.
- Stores:
  - SB, `ea=0x3002`, `arg2=0x12345678` → `be=0100`, `wdata=0x78787878`.
  - SH, `ea=0x3002` → `be=1100`, `wdata=0x56785678`.
  - After rvalid: no `wb_valid_o`; `op_ready_o` is high again.
- LW at `ea=0x1002` → no `mem_req_o`; `err_o=1`, `cause=1` at N+1; an LW accepted at N+1 proceeds normally.
- gnt withheld, `TIMEOUT_CYCLES=8` → `err_o` with `cause=2` exactly once; `mem_req_o` drops; a stale rvalid 3 cycles later produces no writeback.
- `rst` pulsed in WAIT; LB with `rdest=0` → no writeback in either case; `op_ready_o` is 1 the cycle after `rst` deasserts.
